// File: rtl/if_stage_if.sv
// Fetch-stage bus: incrementer/imem return path, hazard/EX controls and the IF/ID register outputs.
interface if_stage_if;
  logic [31:0] pc_incr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;

  modport master (
    output pc_incr, imem_data, stall, redirect, redirect_pc,
    input  pc_out, ifid_instr, ifid_npc, ifid_valid
  );

  modport slave (
    input  pc_incr, imem_data, stall, redirect, redirect_pc,
    output pc_out, ifid_instr, ifid_npc, ifid_valid
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt,
`endif
  if_stage_if.slave   bus
);

  typedef enum logic [1:0] {StBoot, StRun, StHold} fst_e;

  fst_e        fst;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        valid;

  // Every output comes straight from a register; no input reaches an output combinationally.
  assign bus.pc_out     = pc;
  assign bus.ifid_instr = instr;
  assign bus.ifid_npc   = npc;
  assign bus.ifid_valid = valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      fst   <= StBoot;
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
      npc   <= 32'h0;
      valid <= 1'b0;
`ifdef IF_PERF_CNT_EN
      fetch_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
`endif
    end else if (bus.redirect) begin
      // The word fetched this cycle is on the wrong path; replace it with a bubble.
      fst   <= StRun;
      pc    <= bus.redirect_pc;
      instr <= NOP_INSTR;
      npc   <= 32'h0;
      valid <= 1'b0;
`ifdef IF_PERF_CNT_EN
      bubble_cnt <= bubble_cnt + 32'h1;
`endif
    end else if (fst == StBoot || !bus.stall) begin
      // Stall is ignored in the boot cycle so the first fetch always lands.
      fst   <= StRun;
      pc    <= bus.pc_incr;
      instr <= bus.imem_data;
      npc   <= bus.pc_incr;
      valid <= 1'b1;
`ifdef IF_PERF_CNT_EN
      fetch_cnt <= fetch_cnt + 32'h1;
`endif
    end else begin
      fst <= StHold;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by randomized control traffic.
module tb_if_stage;

  localparam logic [31:0] ResetPc  = 32'h0000_0000;
  localparam logic [31:0] NopInstr = 32'h0000_0013;
  localparam logic [31:0] MemBase  = 32'hA000_0000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  if_stage_if bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  if_stage #(
    .RESET_PC  (ResetPc),
    .NOP_INSTR (NopInstr)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt),
`endif
    .bus        (bus)
  );

  // Incrementer and instruction memory: word n holds MemBase + n.
  assign bus.pc_incr   = bus.pc_out + 32'h1;
  assign bus.imem_data = MemBase + bus.pc_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what the fetch stage should be showing after each edge.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_npc;
  logic        m_valid;
  bit          m_boot;
  logic [31:0] m_fetch;
  logic [31:0] m_bubble;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pc_out", bus.pc_out, m_pc);
    check("ifid_instr", bus.ifid_instr, m_instr);
    check("ifid_npc", bus.ifid_npc, m_npc);
    check("ifid_valid", {31'h0, bus.ifid_valid}, {31'h0, m_valid});
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, m_fetch);
    check("bubble_cnt", bubble_cnt, m_bubble);
`endif
  endtask

  // One clock: apply controls, advance the reference by the priority rules, compare after the edge.
  task automatic step(input logic r, input logic st, input logic rd, input logic [31:0] tgt);
    @(negedge clk);
    rst             = r;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = tgt;
    @(posedge clk);
    if (r) begin
      m_pc = ResetPc; m_instr = NopInstr; m_npc = 0; m_valid = 0; m_boot = 1;
      m_fetch = 0; m_bubble = 0;
    end else if (rd) begin
      m_pc = tgt; m_instr = NopInstr; m_npc = 0; m_valid = 0; m_boot = 0;
      m_bubble = m_bubble + 1;
    end else if (m_boot || !st) begin
      m_instr = MemBase + m_pc;
      m_npc   = m_pc + 1;
      m_pc    = m_pc + 1;
      m_valid = 1;
      m_boot  = 0;
      m_fetch = m_fetch + 1;
    end
    #1;
    check_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_pc = 0; m_instr = 0; m_npc = 0; m_valid = 0; m_boot = 0; m_fetch = 0; m_bubble = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;

    // Reset and free run: pc 0,1,2,3 with matching IF/ID contents.
    step(1, 0, 0, 0);
    check("reset_pc", bus.pc_out, 32'h0);
    check("reset_nop", bus.ifid_instr, NopInstr);
    repeat (3) step(0, 0, 0, 0);
    check("run_pc3", bus.pc_out, 32'h3);
    check("run_instr2", bus.ifid_instr, 32'hA000_0002);
    check("run_npc3", bus.ifid_npc, 32'h3);

    // Stall three cycles at pc 5, then resume.
    repeat (2) step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    check("stall_pc", bus.pc_out, 32'h5);
    check("stall_instr", bus.ifid_instr, 32'hA000_0004);
    step(0, 0, 0, 0);
    check("resume_instr", bus.ifid_instr, 32'hA000_0005);
    check("resume_npc", bus.ifid_npc, 32'h6);

    // Redirect at pc 7 to 0x40: one bubble, then the target instruction.
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h40);
    check("redir_pc", bus.pc_out, 32'h40);
    check("redir_bubble", {31'h0, bus.ifid_valid}, 32'h0);
    step(0, 0, 0, 0);
    check("redir_instr", bus.ifid_instr, 32'hA000_0040);
    check("redir_npc", bus.ifid_npc, 32'h41);

    // Stall and redirect together: redirect wins.
    step(0, 1, 1, 32'h80);
    check("both_pc", bus.pc_out, 32'h80);
    step(0, 0, 0, 0);

    // Reset mid-run at pc 0x23, then replay the boot sequence.
    step(0, 0, 1, 32'h20);
    repeat (3) step(0, 0, 0, 0);
    check("pre_rst_pc", bus.pc_out, 32'h23);
    step(1, 0, 0, 0);
    check("mid_rst_pc", bus.pc_out, 32'h0);
    repeat (4) step(0, 0, 0, 0);

    // Stall during the boot cycle is ignored.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    check("boot_stall_pc", bus.pc_out, 32'h1);

    // Randomized control traffic, including targets near the top of the address space.
    for (int i = 0; i < 400; i++) begin
      logic        r, st, rd;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 99) < 3);
      st  = ($urandom_range(0, 99) < 35);
      rd  = ($urandom_range(0, 99) < 12);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
      step(r, st, rd, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
